// File: rtl/exe_stage.sv
// Execute stage between the ID/EXE and EX/MEM pipeline registers: operand forwarding,
// single-cycle ALU, iterative shift-add MUL with upstream stall, registered EX/MEM outputs.
module exe_stage #(
  parameter int MUL_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_mem_to_reg,
  input  logic        id_reg_write,
  input  logic        id_mem_write,
  input  logic        id_mem_read,
  input  logic        id_alu_src,
  input  logic        id_reg_dst,
  input  logic [2:0]  id_alu_op,
  input  logic [31:0] id_read_data1,
  input  logic [31:0] id_read_data2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        exmem_fwd_reg_write,
  input  logic        memwb_fwd_reg_write,
  input  logic [4:0]  exmem_fwd_rd,
  input  logic [4:0]  memwb_fwd_rd,
  input  logic [31:0] exmem_fwd_data,
  input  logic [31:0] memwb_fwd_data,
  output logic        exe_stall,
  output logic        exmem_mem_to_reg,
  output logic        exmem_reg_write,
  output logic        exmem_mem_write,
  output logic        exmem_mem_read,
  output logic [31:0] exmem_alu_result,
  output logic [31:0] exmem_write_data,
  output logic [4:0]  exmem_dst,
  output logic        exmem_zero
);

  localparam int         N        = 32 / MUL_BITS;
  localparam logic [5:0] LAST_CNT = 6'(N - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Forwarding: EX/MEM beats MEM/WB, and register 0 is never forwarded.
  logic        a_from_ex, a_from_wb, b_from_ex, b_from_wb;
  logic [31:0] op_a, b_reg, op_b;

  assign a_from_ex = exmem_fwd_reg_write && (exmem_fwd_rd == id_rs) && (id_rs != 5'd0);
  assign a_from_wb = memwb_fwd_reg_write && (memwb_fwd_rd == id_rs) && (id_rs != 5'd0);
  assign b_from_ex = exmem_fwd_reg_write && (exmem_fwd_rd == id_rt) && (id_rt != 5'd0);
  assign b_from_wb = memwb_fwd_reg_write && (memwb_fwd_rd == id_rt) && (id_rt != 5'd0);

  assign op_a  = a_from_ex ? exmem_fwd_data : (a_from_wb ? memwb_fwd_data : id_read_data1);
  assign b_reg = b_from_ex ? exmem_fwd_data : (b_from_wb ? memwb_fwd_data : id_read_data2);
  assign op_b  = id_alu_src ? id_imm : b_reg;

  logic       is_mul;
  logic [3:0] id_ctrl;
  logic [4:0] id_dst;

  assign is_mul  = (id_alu_op == OP_MUL);
  assign id_ctrl = {id_mem_to_reg, id_reg_write, id_mem_write, id_mem_read};
  assign id_dst  = id_reg_dst ? id_rd : id_rt;

  logic [31:0] alu_res;

  always_comb begin
    alu_res = '0;
    unique case (id_alu_op)
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_ADD: alu_res = op_a + op_b;
      OP_MUL: alu_res = '0;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_NOR: alu_res = ~(op_a | op_b);
      OP_SUB: alu_res = op_a - op_b;
      OP_SLT: alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
    endcase
  end

  // Shift-add multiplier state; the control bundle is captured at start so DONE is self-contained.
  logic [31:0] mcand_q, mplier_q, acc_q, wdata_hold_q;
  logic [5:0]  cnt_q;
  logic [3:0]  ctrl_hold_q;
  logic [4:0]  dst_hold_q;
  logic [31:0] pp [MUL_BITS];
  logic [31:0] step_sum;

  genvar gi;
  generate
    for (gi = 0; gi < MUL_BITS; gi++) begin : g_pp
      assign pp[gi] = mplier_q[gi] ? (mcand_q << gi) : 32'd0;
    end
  endgenerate

  always_comb begin
    step_sum = acc_q;
    for (int k = 0; k < MUL_BITS; k++) begin
      step_sum = step_sum + pp[k];
    end
  end

  logic [3:0]  exm_ctrl_q, exm_ctrl_d;
  logic [31:0] exm_result_q, exm_result_d;
  logic [31:0] exm_wdata_q, exm_wdata_d;
  logic [4:0]  exm_dst_q, exm_dst_d;
  logic        exm_zero_q, exm_zero_d;

  always_comb begin
    state_d      = state_q;
    exe_stall    = 1'b0;
    exm_ctrl_d   = '0;
    exm_result_d = '0;
    exm_wdata_d  = '0;
    exm_dst_d    = '0;
    case (state_q)
      IDLE: begin
        if (is_mul) begin
          exe_stall = 1'b1;
          state_d   = BUSY;
        end else begin
          exm_ctrl_d   = id_ctrl;
          exm_result_d = alu_res;
          exm_wdata_d  = b_reg;
          exm_dst_d    = id_dst;
        end
      end
      BUSY: begin
        exe_stall = 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d      = IDLE;
        exm_ctrl_d   = ctrl_hold_q;
        exm_result_d = acc_q;
        exm_wdata_d  = wdata_hold_q;
        exm_dst_d    = dst_hold_q;
      end
      default: state_d = IDLE;
    endcase
    // Stall must drop the instant reset is applied, without waiting for the state register.
    if (!rst) begin
      exe_stall = 1'b0;
    end
    exm_zero_d = (exm_result_d == 32'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      exm_ctrl_q   <= '0;
      exm_result_q <= '0;
      exm_wdata_q  <= '0;
      exm_dst_q    <= '0;
      exm_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      exm_ctrl_q   <= exm_ctrl_d;
      exm_result_q <= exm_result_d;
      exm_wdata_q  <= exm_wdata_d;
      exm_dst_q    <= exm_dst_d;
      exm_zero_q   <= exm_zero_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      ctrl_hold_q  <= '0;
      dst_hold_q   <= '0;
      wdata_hold_q <= '0;
    end else if (state_q == IDLE && is_mul) begin
      mcand_q      <= op_a;
      mplier_q     <= op_b;
      acc_q        <= '0;
      cnt_q        <= '0;
      ctrl_hold_q  <= id_ctrl;
      dst_hold_q   <= id_dst;
      wdata_hold_q <= b_reg;
    end else if (state_q == BUSY) begin
      acc_q    <= step_sum;
      mcand_q  <= mcand_q << MUL_BITS;
      mplier_q <= mplier_q >> MUL_BITS;
      cnt_q    <= cnt_q + 6'd1;
    end
  end

  assign {exmem_mem_to_reg, exmem_reg_write, exmem_mem_write, exmem_mem_read} = exm_ctrl_q;
  assign exmem_alu_result = exm_result_q;
  assign exmem_write_data = exm_wdata_q;
  assign exmem_dst        = exm_dst_q;
  assign exmem_zero       = exm_zero_q;

endmodule

// File: tb/tb_exe_stage.sv
// Randomized scoreboard bench for exe_stage: stimulus pushes expected EX/MEM contents,
// a monitor pops them whenever a reg-writing result appears and checks bubbles otherwise.
module tb_exe_stage;

  localparam int N_CYC = 32;   // default MUL_BITS = 1

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_mem_to_reg = 0, id_reg_write = 0, id_mem_write = 0, id_mem_read = 0;
  logic        id_alu_src = 0, id_reg_dst = 0;
  logic [2:0]  id_alu_op = 3'b000;
  logic [31:0] id_read_data1 = 0, id_read_data2 = 0, id_imm = 0;
  logic [4:0]  id_rs = 0, id_rt = 0, id_rd = 0;
  logic        exmem_fwd_reg_write = 0, memwb_fwd_reg_write = 0;
  logic [4:0]  exmem_fwd_rd = 0, memwb_fwd_rd = 0;
  logic [31:0] exmem_fwd_data = 0, memwb_fwd_data = 0;
  logic        exe_stall;
  logic        exmem_mem_to_reg, exmem_reg_write, exmem_mem_write, exmem_mem_read;
  logic [31:0] exmem_alu_result, exmem_write_data;
  logic [4:0]  exmem_dst;
  logic        exmem_zero;

  exe_stage dut (
    .clk(clk), .rst(rst),
    .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
    .id_mem_write(id_mem_write), .id_mem_read(id_mem_read),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .exmem_fwd_reg_write(exmem_fwd_reg_write), .memwb_fwd_reg_write(memwb_fwd_reg_write),
    .exmem_fwd_rd(exmem_fwd_rd), .memwb_fwd_rd(memwb_fwd_rd),
    .exmem_fwd_data(exmem_fwd_data), .memwb_fwd_data(memwb_fwd_data),
    .exe_stall(exe_stall),
    .exmem_mem_to_reg(exmem_mem_to_reg), .exmem_reg_write(exmem_reg_write),
    .exmem_mem_write(exmem_mem_write), .exmem_mem_read(exmem_mem_read),
    .exmem_alu_result(exmem_alu_result), .exmem_write_data(exmem_write_data),
    .exmem_dst(exmem_dst), .exmem_zero(exmem_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  dst;
    logic [3:0]  ctrl;
    logic        is_mul;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   txn_id = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", name, act, exp);
    end
  endtask

  // Reference model: forwarding rule and ALU semantics in plain arithmetic.
  function automatic logic [31:0] fwd_val(input logic [4:0] r, input logic [31:0] idv);
    if (r != 5'd0 && exmem_fwd_reg_write && exmem_fwd_rd == r) return exmem_fwd_data;
    if (r != 5'd0 && memwb_fwd_reg_write && memwb_fwd_rd == r) return memwb_fwd_data;
    return idv;
  endfunction

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] prod;
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: begin prod = {32'd0, a} * {32'd0, b}; return prod[31:0]; end
      3'd4: return a ^ b;
      3'd5: return ~(a | b);
      3'd6: return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic set_nop();
    id_alu_op = 3'b000; id_read_data1 = 0; id_read_data2 = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_alu_src = 0; id_reg_dst = 0;
    {id_mem_to_reg, id_reg_write, id_mem_write, id_mem_read} = 4'b0000;
    exmem_fwd_reg_write = 0; memwb_fwd_reg_write = 0;
  endtask

  task automatic rand_fwd();
    exmem_fwd_reg_write = 1'($urandom_range(0, 1));
    memwb_fwd_reg_write = 1'($urandom_range(0, 1));
    exmem_fwd_rd   = 5'($urandom_range(0, 3));
    memwb_fwd_rd   = 5'($urandom_range(0, 3));
    exmem_fwd_data = $urandom;
    memwb_fwd_data = $urandom;
  endtask

  task automatic set_rand();
    id_alu_op     = 3'($urandom_range(0, 7));
    id_read_data1 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
    id_read_data2 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
    id_imm        = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'($urandom_range(0, 50));
    id_rs = 5'($urandom_range(0, 3));
    id_rt = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(4, 31));
    id_alu_src = 1'($urandom_range(0, 1));
    id_reg_dst = 1'($urandom_range(0, 1));
    id_mem_to_reg = 1'($urandom_range(0, 1));
    id_mem_write  = 1'($urandom_range(0, 1));
    id_mem_read   = 1'($urandom_range(0, 1));
    id_reg_write  = 1'b1;
    rand_fwd();
  endtask

  // Caller has set inputs just after a falling edge; this records the expectation and
  // walks through the stall for a MUL.
  task automatic go(input bit churn_fwd);
    exp_t        e;
    logic [31:0] a, breg, b;
    int          n;
    a    = fwd_val(id_rs, id_read_data1);
    breg = fwd_val(id_rt, id_read_data2);
    b    = id_alu_src ? id_imm : breg;
    e.res    = alu_model(id_alu_op, a, b);
    e.wd     = breg;
    e.dst    = id_reg_dst ? id_rd : id_rt;
    e.ctrl   = {id_mem_to_reg, id_reg_write, id_mem_write, id_mem_read};
    e.is_mul = (id_alu_op == 3'd3);
    e.id     = txn_id++;
    sb.push_back(e);
    #1;
    if (!e.is_mul) begin
      chk("stall_alu", 32'(exe_stall), 32'd0);
    end else begin
      n = 0;
      while (exe_stall && n < 200) begin
        n++;
        @(negedge clk);
        if (churn_fwd) rand_fwd();
        #1;
      end
      chk("stall_len", n, N_CYC + 1);
    end
  endtask

  // Monitor: a reg-writing EX/MEM entry is a result; anything else must be an all-zero bubble.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exmem_reg_write === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", exmem_alu_result, 32'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          chk("result", exmem_alu_result, e.res);
          chk("dst", 32'(exmem_dst), 32'(e.dst));
          chk("ctrl", 32'({exmem_mem_to_reg, exmem_reg_write, exmem_mem_write, exmem_mem_read}),
              32'(e.ctrl));
          chk("zero", 32'(exmem_zero), (e.res == 32'd0) ? 32'd1 : 32'd0);
          if (!e.is_mul) chk("write_data", exmem_write_data, e.wd);
          $display("txn %0d: result=%08h dst=%0d mul=%0d", e.id, exmem_alu_result,
                   exmem_dst, e.is_mul);
        end
      end else begin
        chk("bubble_ctrl", 32'({exmem_mem_to_reg, exmem_mem_write, exmem_mem_read}), 32'd0);
        chk("bubble_data", exmem_alu_result | exmem_write_data | 32'(exmem_dst), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state before any clock edge.
    #1;
    chk("reset_stall", 32'(exe_stall), 32'd0);
    chk("reset_outputs", exmem_alu_result | exmem_write_data | 32'(exmem_dst) |
        32'({exmem_mem_to_reg, exmem_reg_write, exmem_mem_write, exmem_mem_read, exmem_zero}),
        32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // EX/MEM forwarding wins over MEM/WB.
    @(negedge clk);
    set_nop(); id_reg_write = 1; id_alu_op = 3'd2;
    id_rs = 5; id_rt = 6; id_read_data1 = 32'd1000; id_read_data2 = 32'd3;
    exmem_fwd_reg_write = 1; exmem_fwd_rd = 5; exmem_fwd_data = 32'd10;
    memwb_fwd_reg_write = 1; memwb_fwd_rd = 5; memwb_fwd_data = 32'd99;
    go(0);
    chk("fwd_priority_model", alu_model(3'd2, fwd_val(5'd5, 32'd1000), 32'd3), 32'd13);

    // Register 0 is never forwarded.
    @(negedge clk);
    set_nop(); id_reg_write = 1; id_alu_op = 3'd2; id_alu_src = 1; id_imm = 0;
    exmem_fwd_reg_write = 1; exmem_fwd_rd = 0; exmem_fwd_data = 32'd7;
    go(0);

    // Signed SUB / SLT with A = -1, B = 1.
    @(negedge clk);
    set_nop(); id_reg_write = 1; id_alu_op = 3'd6; id_rs = 2;
    id_read_data1 = 32'hFFFF_FFFF; id_alu_src = 1; id_imm = 32'd1;
    go(0);
    @(negedge clk);
    id_alu_op = 3'd7;
    go(0);

    // MUL 0xFFFFFFFF * 3 -> 0xFFFFFFFD after a 33-cycle stall; forwarding churns meanwhile.
    @(negedge clk);
    set_nop(); id_reg_write = 1; id_alu_op = 3'd3; id_rs = 1; id_rt = 2; id_reg_dst = 1;
    id_rd = 9; id_read_data1 = 32'hFFFF_FFFF; id_read_data2 = 32'd3;
    go(1);

    // Mid-stream asynchronous reset with a live result in EX/MEM.
    @(negedge clk);
    set_nop(); id_reg_write = 1; id_alu_op = 3'd1; id_read_data1 = 32'h0000_F00D;
    go(0);
    @(negedge clk);
    set_nop();
    #2 rst = 1'b0;
    #1;
    chk("midreset_stall", 32'(exe_stall), 32'd0);
    chk("midreset_outputs", exmem_alu_result | 32'({exmem_reg_write, exmem_zero}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset during BUSY aborts the MUL; a fresh MUL then stalls the full length again.
    @(negedge clk);
    set_nop(); id_reg_write = 1; id_alu_op = 3'd3; id_read_data1 = 32'd5; id_read_data2 = 32'd6;
    #1;
    chk("abort_stall_start", 32'(exe_stall), 32'd1);
    repeat (11) @(negedge clk);
    #1;
    chk("abort_stall_busy", 32'(exe_stall), 32'd1);
    set_nop();
    rst = 1'b0;
    #1;
    chk("abort_stall_reset", 32'(exe_stall), 32'd0);
    chk("abort_outputs", exmem_alu_result | 32'(exmem_reg_write), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    set_nop(); id_reg_write = 1; id_alu_op = 3'd3; id_rs = 3; id_rt = 0;
    id_read_data1 = 32'h1234_5678; id_read_data2 = 32'h0000_0100;
    go(0);

    // Randomized traffic, MUL included.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      set_rand();
      go(i % 2 == 1);
    end

    @(negedge clk);
    set_nop();
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
